// File: rtl/tetris_input_ctrl_pkg.sv
// Shared types for the tetris input controller: engine command encoding,
// button and pending-flag indices, and the issue-priority selector.
package tetris_input_ctrl_pkg;

  typedef enum logic [3:0] {
    NONE       = 4'd0,
    LEFT       = 4'd1,
    RIGHT      = 4'd2,
    DOWN       = 4'd3,
    DROP       = 4'd4,
    HOLD       = 4'd5,
    ROTATE     = 4'd6,
    ROTATE_REV = 4'd7,
    BAR        = 4'd8
  } control_type;

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

  // Auto-repeat channels are the first NUM_RPT button indices.
  localparam int B_LEFT    = 0;
  localparam int B_RIGHT   = 1;
  localparam int B_DOWN    = 2;
  localparam int B_DROP    = 3;
  localparam int B_ROT     = 4;
  localparam int B_ROT_REV = 5;
  localparam int B_HOLD    = 6;
  localparam int B_START   = 7;
  localparam int NUM_BTN   = 8;
  localparam int NUM_RPT   = 3;

  // Bit position doubles as priority: the highest set bit issues first.
  localparam int P_DOWN    = 0;
  localparam int P_DROP    = 1;
  localparam int P_RIGHT   = 2;
  localparam int P_LEFT    = 3;
  localparam int P_ROT_REV = 4;
  localparam int P_ROT     = 5;
  localparam int P_HOLD    = 6;
  localparam int NUM_PEND  = 7;

  typedef struct packed {
    control_type         cmd;
    logic [NUM_PEND-1:0] clr;
  } issue_t;

  function automatic control_type pend_cmd(input int idx);
    case (idx)
      P_DOWN:    return DOWN;
      P_DROP:    return DROP;
      P_RIGHT:   return RIGHT;
      P_LEFT:    return LEFT;
      P_ROT_REV: return ROTATE_REV;
      P_ROT:     return ROTATE;
      P_HOLD:    return HOLD;
      default:   return NONE;
    endcase
  endfunction

  function automatic issue_t pick_cmd(input logic [NUM_PEND-1:0] p);
    issue_t r;
    r.cmd = NONE;
    r.clr = '0;
    for (int i = 0; i < NUM_PEND; i++) begin
      if (p[i]) begin
        r.cmd    = pend_cmd(i);
        r.clr    = '0;
        r.clr[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tetris_input_ctrl_debounce.sv
// One push-button: 2-flop synchroniser, stability-counter debounce and a
// single-cycle press pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Tetris input controller: debounced buttons with auto-repeat and gravity,
// merged into sticky pending flags and issued to the engine one at a time.
module tetris_input_ctrl
  import tetris_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int DAS_CYCLES      = 17000000,
  parameter int ARR_CYCLES      = 5000000,
  parameter int GRAVITY_CYCLES  = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_drop,
  input  logic       btn_rot,
  input  logic       btn_rot_rev,
  input  logic       btn_hold,
  input  logic       btn_start,
  input  logic       pause,
  input  logic       ready,
  output logic [3:0] ctrl,
  output logic [6:0] pending
);
  localparam int RPT_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int RCW     = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam int GCW     = (GRAVITY_CYCLES > 1) ? $clog2(GRAVITY_CYCLES) : 1;

  logic [NUM_BTN-1:0]  raw, lvl, press;
  logic [NUM_RPT-1:0]  rpt_set;
  logic [NUM_PEND-1:0] pend_set;
  logic [GCW-1:0]      gcnt;
  logic                grav_set, issue_en, start_p;
  control_type         ctrl_q;
  issue_t              sel;

  assign raw = {btn_start, btn_hold, btn_rot_rev, btn_rot,
                btn_drop, btn_down, btn_right, btn_left};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[g]),
      .level (lvl[g]),
      .press (press[g])
    );
  end

  for (genvar g = 0; g < NUM_RPT; g++) begin : g_rpt
    rpt_state_t     st, st_n;
    logic [RCW-1:0] cnt, cnt_n;
    logic           set_g;

    always_ff @(posedge clk) begin
      if (reset) begin
        st  <= RPT_IDLE;
        cnt <= '0;
      end else begin
        st  <= st_n;
        cnt <= cnt_n;
      end
    end

    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      set_g = 1'b0;
      case (st)
        RPT_IDLE: if (press[g]) begin
          set_g = 1'b1;
          st_n  = RPT_DELAY;
          cnt_n = '0;
        end
        RPT_DELAY: begin
          if (!lvl[g]) begin
            st_n = RPT_IDLE;
          end else if (cnt == RCW'(DAS_CYCLES - 1)) begin
            set_g = 1'b1;
            st_n  = RPT_REPEAT;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (!lvl[g]) begin
            st_n = RPT_IDLE;
          end else if (cnt == RCW'(ARR_CYCLES - 1)) begin
            set_g = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: st_n = RPT_IDLE;
      endcase
    end

    assign rpt_set[g] = set_g;
  end

  assign start_p  = press[B_START];
  assign grav_set = !pause && (gcnt == GCW'(GRAVITY_CYCLES - 1));

  assign pend_set[P_HOLD]    = press[B_HOLD];
  assign pend_set[P_ROT]     = press[B_ROT];
  assign pend_set[P_ROT_REV] = press[B_ROT_REV];
  assign pend_set[P_LEFT]    = rpt_set[B_LEFT];
  assign pend_set[P_RIGHT]   = rpt_set[B_RIGHT];
  assign pend_set[P_DROP]    = press[B_DROP];
  assign pend_set[P_DOWN]    = rpt_set[B_DOWN] | grav_set;

  // Requiring ctrl==NONE forces an idle cycle between issued commands.
  assign issue_en = ready && !pause && (ctrl_q == NONE) && (|pending);
  assign sel      = pick_cmd(pending);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= NONE;
      pending <= '0;
      gcnt    <= '0;
    end else if (start_p) begin
      ctrl_q  <= DOWN;
      pending <= '0;
      gcnt    <= '0;
    end else begin
      ctrl_q  <= issue_en ? sel.cmd : NONE;
      // New sets are OR-ed after the clear so a same-cycle request survives.
      pending <= (pending & ~(issue_en ? sel.clr : '0)) | pend_set;
      if (issue_en && sel.cmd == DOWN)
        gcnt <= '0;
      else if (!pause)
        gcnt <= grav_set ? '0 : gcnt + 1'b1;
    end
  end

  assign ctrl = ctrl_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: directed scenarios then random buttons, checked
// every cycle against a behavioural model built from the button/issue rules.
module tb_tetris_input_ctrl;
  localparam int D_P = 4, DAS_P = 10, ARR_P = 3, G_P = 50;

  logic       clk = 1'b0, reset = 1'b1, pause = 1'b0, ready = 1'b0;
  logic [7:0] btn = '0;
  logic [3:0] ctrl;
  logic [6:0] pending;
  int total = 0, bad = 0, cyc = 0;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(D_P), .DAS_CYCLES(DAS_P),
    .ARR_CYCLES(ARR_P), .GRAVITY_CYCLES(G_P)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_left(btn[0]), .btn_right(btn[1]), .btn_down(btn[2]), .btn_drop(btn[3]),
    .btn_rot(btn[4]), .btn_rot_rev(btn[5]), .btn_hold(btn[6]), .btn_start(btn[7]),
    .pause(pause), .ready(ready), .ctrl(ctrl), .pending(pending)
  );

  always #5 clk = ~clk;

  // model state: button b = 0 left,1 right,2 down,3 drop,4 rot,5 rot_rev,6 hold,7 start
  bit       m_s1[8], m_s2[8], m_lvl[8], m_lvl_d[8];
  int       m_run[8];
  bit       m_act[3];
  int       m_age[3];
  int       m_grav, m_ctrl;
  bit [6:0] m_pend;
  int       rbit[3]   = '{3, 2, 0};
  int       cmd_of[7] = '{3, 4, 2, 1, 7, 6, 5};

  function automatic void model_edge();
    bit [7:0] pr;
    bit [6:0] set;
    int       hi;
    bit       issue, ghit;
    if (reset) begin
      for (int b = 0; b < 8; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_lvl_d[b] = 0; m_run[b] = 0;
      end
      for (int c = 0; c < 3; c++) begin m_act[c] = 0; m_age[c] = 0; end
      m_grav = 0; m_pend = '0; m_ctrl = 0;
      return;
    end
    for (int b = 0; b < 8; b++) pr[b] = m_lvl[b] && !m_lvl_d[b];
    set = '0;
    // hold age: request at press, at DAS, then every ARR while level stays high
    for (int c = 0; c < 3; c++) begin
      if (!m_act[c]) begin
        if (pr[c]) begin set[rbit[c]] = 1; m_act[c] = 1; m_age[c] = 0; end
      end else if (!m_lvl[c]) begin
        m_act[c] = 0;
      end else begin
        m_age[c]++;
        if (m_age[c] == DAS_P || (m_age[c] > DAS_P && (m_age[c] - DAS_P) % ARR_P == 0))
          set[rbit[c]] = 1;
      end
    end
    set[6] = set[6] | pr[6];
    set[5] = set[5] | pr[4];
    set[4] = set[4] | pr[5];
    set[1] = set[1] | pr[3];
    ghit = !pause && (m_grav == G_P - 1);
    if (ghit) set[0] = 1;
    issue = ready && !pause && (m_ctrl == 0) && (m_pend != 0);
    hi = 0;
    for (int i = 0; i < 7; i++) if (m_pend[i]) hi = i;
    if (pr[7]) begin
      m_ctrl = 3; m_pend = '0; m_grav = 0;
    end else begin
      m_ctrl = issue ? cmd_of[hi] : 0;
      if (issue) m_pend[hi] = 0;
      m_pend = m_pend | set;
      if (issue && cmd_of[hi] == 3) m_grav = 0;
      else if (!pause) m_grav = ghit ? 0 : m_grav + 1;
    end
    for (int b = 0; b < 8; b++) begin
      m_lvl_d[b] = m_lvl[b];
      if (m_s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == D_P) begin m_lvl[b] = m_s2[b]; m_run[b] = 0; end
      end else m_run[b] = 0;
      m_s2[b] = m_s1[b];
      m_s1[b] = btn[b];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("ctrl", 32'(ctrl), 32'(m_ctrl));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  int seq[$], at[$];

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, first, nd, nother;
    bit found;
    repeat (3) tick();
    chk("rst_ctrl0", 32'(ctrl), 0);
    chk("rst_pend0", 32'(pending), 0);
    reset = 1'b0;
    ready = 1'b1;

    // glitchy left, then 6 stable samples
    repeat (3) begin
      btn[0] = 1; tick(); tick();
      btn[0] = 0; tick(); tick();
    end
    btn[0] = 1; nl = 0; first = -1;
    for (int i = 1; i <= 26; i++) begin
      if (i == 7) btn[0] = 0;
      tick();
      if (ctrl == 4'd1) begin nl++; if (first < 0) first = i; end
    end
    chk("glitch_left_cnt", nl, 1);
    chk("glitch_left_lat", first, D_P + 4);

    // left held 30 cycles: press, DAS, then every ARR while debounced level is high
    btn[0] = 1; nl = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 31) btn[0] = 0;
      tick();
      if (ctrl == 4'd1) nl++;
    end
    chk("rpt_left_cnt", nl, 2 + (30 - 2 - DAS_P) / ARR_P);

    // rot, hold, drop together while engine busy
    ready = 0; btn[4] = 1; btn[6] = 1; btn[3] = 1;
    repeat (8) tick();
    btn[4] = 0; btn[6] = 0; btn[3] = 0;
    repeat (5) tick();
    ready = 1; seq.delete(); at.delete();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ctrl != 0) begin seq.push_back(int'(ctrl)); at.push_back(i); end
    end
    chk("seq_len", 32'(seq.size() >= 3), 1);
    chk("seq0_hold", seq[0], 5);
    chk("seq1_rot", seq[1], 6);
    chk("seq2_drop", seq[2], 4);
    chk("gap01", 32'(at[1] - at[0] >= 2), 1);
    chk("gap12", 32'(at[2] - at[1] >= 2), 1);

    // gravity
    repeat (30) tick();
    nd = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (ctrl == 4'd3) nd++; end
    chk("grav_cnt", nd, 100 / G_P);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin tick(); if (ctrl == 4'd3) found = 1; end
    chk("grav_seen", 32'(found), 1);
    pause = 1; nd = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (ctrl != 0) nd++; end
    chk("pause_quiet", nd, 0);
    chk("pause_pend", 32'(pending), 0);
    pause = 0;

    // start while busy with LEFT and DOWN pending
    ready = 0; btn[0] = 1; btn[2] = 1;
    repeat (7) tick();
    btn[0] = 0; btn[2] = 0;
    repeat (10) tick();
    chk("pre_start_pend", 32'(pending), 32'(7'b0001001));
    btn[7] = 1; nd = 0; nother = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) btn[7] = 0;
      tick();
      if (ctrl == 4'd3) nd++; else if (ctrl != 0) nother++;
    end
    chk("start_down", nd, 1);
    chk("start_other", nother, 0);
    chk("post_start_pend", 32'(pending), 0);

    // reset in the middle of a left repeat
    ready = 1; repeat (5) tick();
    btn[0] = 1; repeat (25) tick();
    reset = 1; btn[0] = 0; tick();
    chk("midrst_ctrl", 32'(ctrl), 0);
    chk("midrst_pend", 32'(pending), 0);
    reset = 0; nl = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (ctrl == 4'd1) nl++; end
    chk("midrst_no_left", nl, 0);

    // random buttons, ready, pause and occasional reset
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(b < 3 ? 24 : (b == 7 ? 59 : 9)) == 0) btn[b] = ~btn[b];
      ready = ($urandom_range(3) != 0);
      if ($urandom_range(49) == 0) pause = ~pause;
      reset = ($urandom_range(599) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
